acia6551_fifo: RTL and testbench

- Synthesisable 6551-compatible ACIA that replaces the Dragon 64 serial stub at the PIA-aliased window (FF04–FF07, selected by cpu_addr[2]).
- Provides a real async 8N1 transmitter and receiver with a 6551 baud-rate table and parametrised RX/TX FIFOs.
- Drives an active-high IRQ that the system ORs into the CPU IRQ line.

---
 rtl/acia6551_fifo.sv | 435 ++++++++++++++++++++++++++++++++++++++++
 tb/tb_acia6551_fifo.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/acia6551_fifo.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : acia6551_fifo                                                |
// | Description : 6551-compatible ACIA with an async 8N1 transmitter and       |
// |               receiver, a 6551 baud-rate table and RX/TX byte FIFOs.       |
// |               Produces an active-high IRQ for the CPU interrupt line.      |
// | Ports       : clk       system clock                                       |
// |               reset     asynchronous active-low reset                      |
// |               addr      register select (0 data, 1 status, 2 cmd, 3 ctrl)  |
// |               strobe    chip select, high for the whole CPU access         |
// |               we        write qualifier, valid while strobe is high        |
// |               data_in   CPU write data                                     |
// |               data_out  read data, combinational from addr                 |
// |               rxd       asynchronous serial input                          |
// |               txd       serial output, idles high                          |
// |               irq       interrupt request, active high                     |
// | Revision    : 1.0  initial release                                         |
// +----------------------------------------------------------------------------+

module acia6551_fifo #(
  parameter int CLK_HZ   = 42954540,
  parameter int RX_DEPTH = 16,
  parameter int TX_DEPTH = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] addr,
  input  logic       strobe,
  input  logic       we,
  input  logic [7:0] data_in,
  output logic [7:0] data_out,
  input  logic       rxd,
  output logic       txd,
  output logic       irq
);

  // Slowest rate (50 baud) sets the divider width.
  localparam int c_DIV_W = $clog2(CLK_HZ / 800 + 2);
  localparam int c_RAW   = $clog2(RX_DEPTH);
  localparam int c_TAW   = $clog2(TX_DEPTH);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_START = 2'd1,
    S_DATA  = 2'd2,
    S_STOP  = 2'd3
  } state_t;

  // Baud rates scaled by 100 so the two fractional rates stay exact.
  function automatic longint f_baud100(input int sel);
    case (sel)
      1:       return 64'd5000;
      2:       return 64'd7500;
      3:       return 64'd10992;
      4:       return 64'd13458;
      5:       return 64'd15000;
      6:       return 64'd30000;
      7:       return 64'd60000;
      8:       return 64'd120000;
      9:       return 64'd180000;
      10:      return 64'd240000;
      11:      return 64'd360000;
      12:      return 64'd480000;
      13:      return 64'd720000;
      14:      return 64'd960000;
      15:      return 64'd1920000;
      default: return 64'd0;
    endcase
  endfunction

  // round(CLK_HZ / (16 * baud)) in integer arithmetic.
  function automatic longint f_div(input int sel);
    longint b;
    b = f_baud100(sel);
    if (b == 0) return 64'd1;
    return (longint'(CLK_HZ) * 100 + 8 * b) / (16 * b);
  endfunction

  logic [c_DIV_W-1:0] w_div_tab [16];
  for (genvar g = 0; g < 16; g++) begin : g_div_tab
    localparam longint c_D = (f_div(g) < 1) ? 64'd1 : f_div(g);
    assign w_div_tab[g] = c_DIV_W'(c_D);
  end

  // ---------------------------------------------------------------- bus
  logic       r_stb, r_a_we;
  logic [1:0] r_a_addr;
  logic [7:0] r_a_data;
  logic       w_commit, w_rd0, w_wr0, w_prst, w_cmd_wr, w_ctrl_wr;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_stb    <= 1'b0;
      r_a_we   <= 1'b0;
      r_a_addr <= 2'd0;
      r_a_data <= 8'h00;
    end else begin
      r_stb <= strobe;
      if (strobe) begin
        r_a_we   <= we;
        r_a_addr <= addr;
        r_a_data <= data_in;
      end
    end
  end

  // One side effect per access, taken on the trailing edge of strobe.
  assign w_commit  = r_stb & ~strobe;
  assign w_rd0     = w_commit & ~r_a_we & (r_a_addr == 2'd0);
  assign w_wr0     = w_commit &  r_a_we & (r_a_addr == 2'd0);
  assign w_prst    = w_commit &  r_a_we & (r_a_addr == 2'd1);
  assign w_cmd_wr  = w_commit &  r_a_we & (r_a_addr == 2'd2);
  assign w_ctrl_wr = w_commit &  r_a_we & (r_a_addr == 2'd3);

  logic [7:0] r_cmd, r_ctrl;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_cmd  <= 8'h00;
      r_ctrl <= 8'h00;
    end else begin
      if (w_cmd_wr)    r_cmd      <= r_a_data;
      else if (w_prst) r_cmd[4:0] <= 5'd0;
      if (w_ctrl_wr)   r_ctrl     <= r_a_data;
    end
  end

  // ------------------------------------------------------- baud generator
  logic [c_DIV_W-1:0] r_bcnt, w_div;
  logic               r_tick, w_run;

  assign w_div = w_div_tab[r_ctrl[3:0]];
  assign w_run = (r_ctrl[3:0] != 4'd0);

  // r_tick is a one-clk pulse every w_div clocks (16x the bit rate).
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_bcnt <= '0;
      r_tick <= 1'b0;
    end else if (w_ctrl_wr || !w_run) begin
      r_bcnt <= '0;
      r_tick <= 1'b0;
    end else if (r_bcnt >= w_div - c_DIV_W'(1)) begin
      r_bcnt <= '0;
      r_tick <= 1'b1;
    end else begin
      r_bcnt <= r_bcnt + c_DIV_W'(1);
      r_tick <= 1'b0;
    end
  end

  // ------------------------------------------------------------ RX FIFO
  logic [7:0]   r_rxq [RX_DEPTH];
  logic [c_RAW:0] r_rx_wp, r_rx_rp;
  logic         w_rx_empty, w_rx_full, w_rx_do_pop, w_rx_do_push, w_rx_push;
  logic [7:0]   w_rx_head, r_rx_last, r_rx_sh;

  assign w_rx_empty   = (r_rx_wp == r_rx_rp);
  assign w_rx_full    = (r_rx_wp[c_RAW] != r_rx_rp[c_RAW]) &&
                        (r_rx_wp[c_RAW-1:0] == r_rx_rp[c_RAW-1:0]);
  assign w_rx_do_pop  = w_rd0 & ~w_rx_empty;
  assign w_rx_do_push = w_rx_push & (~w_rx_full | w_rx_do_pop);
  assign w_rx_head    = r_rxq[r_rx_rp[c_RAW-1:0]];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_rx_wp   <= '0;
      r_rx_rp   <= '0;
      r_rx_last <= 8'h00;
    end else begin
      if (w_rx_do_pop) r_rx_last <= w_rx_head;
      if (w_prst) begin
        r_rx_wp <= '0;
        r_rx_rp <= '0;
      end else begin
        if (w_rx_do_push) r_rx_wp <= r_rx_wp + (c_RAW+1)'(1);
        if (w_rx_do_pop)  r_rx_rp <= r_rx_rp + (c_RAW+1)'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (w_rx_do_push) r_rxq[r_rx_wp[c_RAW-1:0]] <= r_rx_sh;
  end

  // ------------------------------------------------------------ TX FIFO
  logic [7:0]   r_txq [TX_DEPTH];
  logic [c_TAW:0] r_tx_wp, r_tx_rp;
  logic         w_tx_empty, w_tx_full, w_tx_pop, w_tx_do_push;
  logic [7:0]   w_tx_head;

  assign w_tx_empty   = (r_tx_wp == r_tx_rp);
  assign w_tx_full    = (r_tx_wp[c_TAW] != r_tx_rp[c_TAW]) &&
                        (r_tx_wp[c_TAW-1:0] == r_tx_rp[c_TAW-1:0]);
  assign w_tx_do_push = w_wr0 & (~w_tx_full | w_tx_pop);
  assign w_tx_head    = r_txq[r_tx_rp[c_TAW-1:0]];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_tx_wp <= '0;
      r_tx_rp <= '0;
    end else if (w_prst) begin
      r_tx_wp <= '0;
      r_tx_rp <= '0;
    end else begin
      if (w_tx_do_push) r_tx_wp <= r_tx_wp + (c_TAW+1)'(1);
      if (w_tx_pop)     r_tx_rp <= r_tx_rp + (c_TAW+1)'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (w_tx_do_push) r_txq[r_tx_wp[c_TAW-1:0]] <= data_in_q();
  end

  function automatic logic [7:0] data_in_q();
    return r_a_data;
  endfunction

  // ------------------------------------------------------------ RX path
  logic   r_rx_s1, r_rx_s2, r_rx_s3, w_rx_fall;
  state_t r_rx_st, w_rx_st_nxt;
  logic [3:0] r_rx_tk, w_rx_tk_nxt;
  logic [2:0] r_rx_bit, w_rx_bit_nxt;
  logic [7:0] w_rx_sh_nxt;
  logic       w_rx_fe_evt, w_rx_ovr_evt;

  assign w_rx_fall    = r_rx_s3 & ~r_rx_s2;
  assign w_rx_ovr_evt = w_rx_push & w_rx_full & ~w_rx_do_pop;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_rx_s1  <= 1'b1;
      r_rx_s2  <= 1'b1;
      r_rx_s3  <= 1'b1;
      r_rx_st  <= S_IDLE;
      r_rx_tk  <= 4'd0;
      r_rx_bit <= 3'd0;
      r_rx_sh  <= 8'h00;
    end else begin
      r_rx_s1  <= rxd;
      r_rx_s2  <= r_rx_s1;
      r_rx_s3  <= r_rx_s2;
      r_rx_st  <= w_rx_st_nxt;
      r_rx_tk  <= w_rx_tk_nxt;
      r_rx_bit <= w_rx_bit_nxt;
      r_rx_sh  <= w_rx_sh_nxt;
    end
  end

  always_comb begin
    w_rx_st_nxt  = r_rx_st;
    w_rx_tk_nxt  = r_rx_tk;
    w_rx_bit_nxt = r_rx_bit;
    w_rx_sh_nxt  = r_rx_sh;
    w_rx_push    = 1'b0;
    w_rx_fe_evt  = 1'b0;
    if (w_ctrl_wr) begin
      w_rx_st_nxt = S_IDLE;
    end else begin
      case (r_rx_st)
        S_IDLE: begin
          if (w_rx_fall && r_cmd[0]) begin
            w_rx_st_nxt = S_START;
            w_rx_tk_nxt = 4'd0;
          end
        end
        S_START: begin
          if (r_tick) begin
            w_rx_tk_nxt = r_rx_tk + 4'd1;
            // Eighth tick is mid start bit: a high line here was a glitch.
            if (r_rx_tk == 4'd7) begin
              w_rx_tk_nxt  = 4'd0;
              w_rx_bit_nxt = 3'd0;
              w_rx_st_nxt  = r_rx_s2 ? S_IDLE : S_DATA;
            end
          end
        end
        S_DATA: begin
          if (r_tick) begin
            w_rx_tk_nxt = r_rx_tk + 4'd1;
            if (r_rx_tk == 4'd15) begin
              w_rx_sh_nxt  = {r_rx_s2, r_rx_sh[7:1]};
              w_rx_bit_nxt = r_rx_bit + 3'd1;
              if (r_rx_bit == 3'd7) w_rx_st_nxt = S_STOP;
            end
          end
        end
        S_STOP: begin
          if (r_tick) begin
            w_rx_tk_nxt = r_rx_tk + 4'd1;
            if (r_rx_tk == 4'd15) begin
              w_rx_push   = 1'b1;
              w_rx_fe_evt = ~r_rx_s2;
              w_rx_st_nxt = S_IDLE;
            end
          end
        end
        default: w_rx_st_nxt = S_IDLE;
      endcase
    end
  end

  logic r_ovr, r_fe;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_ovr <= 1'b0;
      r_fe  <= 1'b0;
    end else begin
      if (w_rd0 || w_prst) begin
        r_ovr <= 1'b0;
        r_fe  <= 1'b0;
      end
      if (w_rx_ovr_evt) r_ovr <= 1'b1;
      if (w_rx_fe_evt)  r_fe  <= 1'b1;
    end
  end

  // ------------------------------------------------------------ TX path
  state_t     r_tx_st, w_tx_st_nxt;
  logic [3:0] r_tx_tk, w_tx_tk_nxt;
  logic [2:0] r_tx_bit, w_tx_bit_nxt;
  logic [7:0] r_tx_sh, w_tx_sh_nxt;
  logic       w_tx_line;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_tx_st  <= S_IDLE;
      r_tx_tk  <= 4'd0;
      r_tx_bit <= 3'd0;
      r_tx_sh  <= 8'h00;
    end else begin
      r_tx_st  <= w_tx_st_nxt;
      r_tx_tk  <= w_tx_tk_nxt;
      r_tx_bit <= w_tx_bit_nxt;
      r_tx_sh  <= w_tx_sh_nxt;
    end
  end

  always_comb begin
    w_tx_st_nxt  = r_tx_st;
    w_tx_tk_nxt  = r_tx_tk;
    w_tx_bit_nxt = r_tx_bit;
    w_tx_sh_nxt  = r_tx_sh;
    w_tx_pop     = 1'b0;
    if (w_ctrl_wr || w_prst) begin
      w_tx_st_nxt = S_IDLE;
    end else begin
      case (r_tx_st)
        S_IDLE: begin
          if (!w_tx_empty && w_run) begin
            w_tx_pop    = 1'b1;
            w_tx_sh_nxt = w_tx_head;
            w_tx_tk_nxt = 4'd0;
            w_tx_st_nxt = S_START;
          end
        end
        S_START: begin
          if (r_tick) begin
            w_tx_tk_nxt = r_tx_tk + 4'd1;
            if (r_tx_tk == 4'd15) begin
              w_tx_bit_nxt = 3'd0;
              w_tx_st_nxt  = S_DATA;
            end
          end
        end
        S_DATA: begin
          if (r_tick) begin
            w_tx_tk_nxt = r_tx_tk + 4'd1;
            if (r_tx_tk == 4'd15) begin
              w_tx_sh_nxt  = {1'b1, r_tx_sh[7:1]};
              w_tx_bit_nxt = r_tx_bit + 3'd1;
              if (r_tx_bit == 3'd7) w_tx_st_nxt = S_STOP;
            end
          end
        end
        S_STOP: begin
          if (r_tick) begin
            w_tx_tk_nxt = r_tx_tk + 4'd1;
            if (r_tx_tk == 4'd15) begin
              // Chain straight into the next start bit when data is waiting.
              if (!w_tx_empty && w_run) begin
                w_tx_pop    = 1'b1;
                w_tx_sh_nxt = w_tx_head;
                w_tx_st_nxt = S_START;
              end else begin
                w_tx_st_nxt = S_IDLE;
              end
            end
          end
        end
        default: w_tx_st_nxt = S_IDLE;
      endcase
    end
  end

  always_comb begin
    w_tx_line = 1'b1;
    case (r_tx_st)
      S_START: w_tx_line = 1'b0;
      S_DATA:  w_tx_line = r_tx_sh[0];
      default: w_tx_line = 1'b1;
    endcase
  end

  // Echo masks the transmitter without stopping it.
  assign txd = r_cmd[4] ? r_rx_s2 : w_tx_line;

  // ---------------------------------------------------------- IRQ/status
  logic       r_irq;
  logic [7:0] w_status;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_irq <= 1'b0;
    else        r_irq <= (~w_rx_empty & r_cmd[0] & ~r_cmd[1]) |
                         (~w_tx_full & (r_cmd[3:2] == 2'b01));
  end

  assign irq      = r_irq;
  assign w_status = {r_irq, 1'b0, 1'b0, ~w_tx_full, ~w_rx_empty, r_ovr, r_fe, 1'b0};

  always_comb begin
    data_out = 8'h00;
    case (addr)
      2'd0: data_out = w_rx_empty ? r_rx_last : w_rx_head;
      2'd1: data_out = w_status;
      2'd2: data_out = r_cmd;
      2'd3: data_out = r_ctrl;
      default: data_out = 8'h00;
    endcase
  end

endmodule

`default_nettype wire

// File: tb/tb_acia6551_fifo.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_acia6551_fifo                                             |
// | Description : Directed self-checking bench for acia6551_fifo. The clock    |
// |               is scaled so 19200 baud gives divisor 7 (112 clk per bit).   |
// | Revision    : 1.0  initial release                                         |
// +----------------------------------------------------------------------------+

module tb_acia6551_fifo;

  localparam int c_CLK_HZ = 2150400;   // 2150400 / (16*19200) = 7
  localparam int c_BIT    = 112;       // clocks per bit at 19200

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic [1:0] addr = 2'd0;
  logic       strobe = 1'b0;
  logic       we = 1'b0;
  logic [7:0] data_in = 8'h00;
  logic [7:0] data_out;
  logic       rxd = 1'b1;
  logic       txd;
  logic       irq;

  int n_vec = 0;
  int n_err = 0;
  int cyc   = 0;

  acia6551_fifo #(
    .CLK_HZ  (c_CLK_HZ),
    .RX_DEPTH(16),
    .TX_DEPTH(4)
  ) u_dut (
    .clk     (clk),
    .reset   (reset),
    .addr    (addr),
    .strobe  (strobe),
    .we      (we),
    .data_in (data_in),
    .data_out(data_out),
    .rxd     (rxd),
    .txd     (txd),
    .irq     (irq)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic cpu_write(input logic [1:0] a, input logic [7:0] d);
    addr = a; we = 1'b1; data_in = d; strobe = 1'b1;
    @(negedge clk);
    strobe = 1'b0; we = 1'b0;
    @(negedge clk);
  endtask

  task automatic cpu_read(input logic [1:0] a, output logic [7:0] d);
    addr = a; we = 1'b0; strobe = 1'b1;
    @(negedge clk);
    d = data_out;
    strobe = 1'b0;
    @(negedge clk);
  endtask

  task automatic send_rx(input logic [7:0] b, input logic stop_bit);
    rxd = 1'b0;
    repeat (c_BIT) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rxd = b[i];
      repeat (c_BIT) @(negedge clk);
    end
    rxd = stop_bit;
    repeat (c_BIT) @(negedge clk);
    rxd = 1'b1;
    repeat (16) @(negedge clk);
  endtask

  task automatic wait_txd(input logic lvl, output logic seen);
    int n;
    n = 0;
    while (txd !== lvl && n < 3000) begin
      @(negedge clk);
      n++;
    end
    seen = (txd === lvl);
  endtask

  // Finds a start bit and samples every bit near its centre.
  task automatic tx_capture(output logic seen, output logic st, output logic [7:0] b,
                            output logic sp, output int t_fall);
    wait_txd(1'b0, seen);
    t_fall = cyc;
    repeat (c_BIT / 2) @(negedge clk);
    st = txd;
    for (int i = 0; i < 8; i++) begin
      repeat (c_BIT) @(negedge clk);
      b[i] = txd;
    end
    repeat (c_BIT) @(negedge clk);
    sp = txd;
  endtask

  initial begin
    repeat (100000) @(posedge clk);
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    logic [7:0] rd;
    logic       seen, st, sp;
    logic [7:0] b;
    int         t1, t2, zeros;

    repeat (5) @(negedge clk);
    reset = 1'b1;
    repeat (2) @(negedge clk);

    // 1. reset state
    cpu_read(2'd1, rd); chk("rst_status", rd, 8'h10);
    chk("rst_txd", txd, 1'b1);
    chk("rst_irq", irq, 1'b0);
    cpu_read(2'd0, rd); chk("rst_rxdata", rd, 8'h00);
    cpu_read(2'd2, rd); chk("rst_cmd", rd, 8'h00);
    cpu_read(2'd3, rd); chk("rst_ctrl", rd, 8'h00);

    // 2. transmitter: load two bytes with the generator stopped, then start it
    cpu_write(2'd0, 8'h55);
    cpu_write(2'd0, 8'h81);
    repeat (20) @(negedge clk);
    chk("tx_held_stopped", txd, 1'b1);
    cpu_read(2'd1, rd); chk("tx_tdre_2q", rd, 8'h10);
    cpu_write(2'd3, 8'h0F);
    tx_capture(seen, st, b, sp, t1);
    chk("tx1_seen", seen, 1'b1);
    chk("tx1_start", st, 1'b0);
    chk("tx1_byte", b, 8'h55);
    chk("tx1_stop", sp, 1'b1);
    tx_capture(seen, st, b, sp, t2);
    chk("tx2_seen", seen, 1'b1);
    chk("tx2_start", st, 1'b0);
    chk("tx2_byte", b, 8'h81);
    chk("tx2_stop", sp, 1'b1);
    // 10 bits of 112 clk, first start bit may be up to one tick (7 clk) short
    chk("tx_frame_len", (t2 - t1 >= 1113) && (t2 - t1 <= 1120), 1'b1);
    cpu_read(2'd1, rd); chk("tx_tdre_after", rd, 8'h10);
    repeat (100) @(negedge clk);

    // 3. single received byte with RX interrupt
    cpu_write(2'd2, 8'h01);
    send_rx(8'hA3, 1'b1);
    cpu_read(2'd1, rd); chk("rx_status_full", rd, 8'h98);
    chk("rx_irq_set", irq, 1'b1);
    cpu_read(2'd0, rd); chk("rx_byte", rd, 8'hA3);
    cpu_read(2'd1, rd); chk("rx_status_empty", rd, 8'h10);
    chk("rx_irq_clr", irq, 1'b0);

    // 4. overrun: 17 frames into a 16-deep FIFO
    for (int i = 0; i < 17; i++) send_rx(8'h30 + 8'(i), 1'b1);
    cpu_read(2'd1, rd); chk("ovr_status", rd, 8'h9C);
    cpu_read(2'd0, rd); chk("ovr_rd0", rd, 8'h30);
    cpu_read(2'd1, rd); chk("ovr_cleared", rd, 8'h98);
    for (int i = 1; i < 16; i++) begin
      cpu_read(2'd0, rd);
      chk($sformatf("ovr_rd%0d", i), rd, 8'h30 + 8'(i));
    end
    cpu_read(2'd0, rd); chk("empty_pop_last", rd, 8'h3F);
    cpu_read(2'd1, rd); chk("ovr_drained", rd, 8'h10);

    // 5. framing error and start glitch
    send_rx(8'h3C, 1'b0);
    cpu_read(2'd1, rd); chk("fe_status", rd, 8'h9A);
    cpu_read(2'd0, rd); chk("fe_byte", rd, 8'h3C);
    cpu_read(2'd1, rd); chk("fe_cleared", rd, 8'h10);
    rxd = 1'b0;
    repeat (28) @(negedge clk);
    rxd = 1'b1;
    repeat (1200) @(negedge clk);
    cpu_read(2'd1, rd); chk("glitch_nopush", rd, 8'h10);

    // echo: txd follows rxd
    cpu_write(2'd2, 8'h10);
    rxd = 1'b0;
    repeat (4) @(negedge clk);
    chk("echo_low", txd, 1'b0);
    rxd = 1'b1;
    repeat (4) @(negedge clk);
    chk("echo_high", txd, 1'b1);

    // 6. TX interrupt, full FIFO, programmed reset mid-frame
    cpu_write(2'd2, 8'h05);
    repeat (2) @(negedge clk);
    chk("txirq_set", irq, 1'b1);
    // first byte moves straight to the shift register, next four fill the FIFO,
    // the sixth is dropped
    for (int i = 0; i < 6; i++) cpu_write(2'd0, 8'h11 + 8'(i));
    cpu_read(2'd1, rd); chk("txfull_status", rd, 8'h00);
    chk("txfull_irq", irq, 1'b0);
    wait_txd(1'b1, seen); chk("pr_bit0_seen", seen, 1'b1);
    wait_txd(1'b0, seen); chk("pr_bit1_seen", seen, 1'b1);
    repeat (20) @(negedge clk);
    chk("pr_txd_mid", txd, 1'b0);
    cpu_write(2'd1, 8'h00);
    chk("pr_txd_idle", txd, 1'b1);
    zeros = 0;
    for (int i = 0; i < 1200; i++) begin
      @(negedge clk);
      if (txd !== 1'b1) zeros++;
    end
    chk("pr_no_more_tx", zeros, 0);
    cpu_read(2'd1, rd); chk("pr_status", rd, 8'h10);
    cpu_read(2'd2, rd); chk("pr_cmd", rd, 8'h00);
    cpu_read(2'd3, rd); chk("pr_ctrl_kept", rd, 8'h0F);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

`default_nettype wire
